// File: rtl/mdu_divider_if.sv
// Handshake/data bundle between the execute stage and the iterative divider.
//   master : execute stage (drives start/op/operands/flush, receives busy/valid/result)
//   slave  : mdu_divider
interface mdu_divider_if #(
  parameter int unsigned XLEN = 32
);
  logic            div_start_i;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] div_dividend_i;
  logic [XLEN-1:0] div_divisor_i;
  logic            div_flush_i;
  logic            div_busy_o;
  logic            div_valid_o;
  logic [XLEN-1:0] div_result_o;

  modport master (
    output div_start_i, div_op_i, div_dividend_i, div_divisor_i, div_flush_i,
    input  div_busy_o, div_valid_o, div_result_o
  );

  modport slave (
    input  div_start_i, div_op_i, div_dividend_i, div_divisor_i, div_flush_i,
    output div_busy_o, div_valid_o, div_result_o
  );
endinterface

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mdu_divider_if.slave
//          div_start_i/div_op_i/div_dividend_i/div_divisor_i : request, sampled when not busy
//          div_flush_i : abort any operation in flight
//          div_busy_o  : high while iterating
//          div_valid_o : one-cycle result pulse
//          div_result_o: quotient/remainder, held until the next completion
module mdu_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  mdu_divider_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StSign = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = '1;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // dvd_q shifts the dividend out and the quotient in; in StFix it holds the special result.
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            op_rem_q, op_rem_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;

  logic [XLEN:0]   rem_shift, rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] sign_result, fin_result;
  logic            done, busy, valid, accept;
  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    // 33-bit compare: the shifted remainder can exceed 32 bits when |divisor| >= 2^31.
    rem_ge    = rem_shift >= {1'b0, dvs_q};

    if (op_rem_q) begin
      sign_result = neg_rem_q ? -rem_q : rem_q;
    end else begin
      sign_result = neg_quot_q ? -dvd_q : dvd_q;
    end
    fin_result = (state_q == StFix) ? dvd_q : sign_result;

    done   = (state_q == StSign) || (state_q == StFix);
    busy   = (state_q == StCalc);
    valid  = done && !bus.div_flush_i;
    accept = bus.div_start_i && !bus.div_flush_i && !busy;

    is_signed = !bus.div_op_i[0];
    a_neg     = is_signed && bus.div_dividend_i[XLEN-1];
    b_neg     = is_signed && bus.div_divisor_i[XLEN-1];
    abs_a     = a_neg ? -bus.div_dividend_i : bus.div_dividend_i;
    abs_b     = b_neg ? -bus.div_divisor_i : bus.div_divisor_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    result_d   = result_q;
    op_rem_d   = op_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;

    if (bus.div_flush_i) begin
      state_d = StIdle;
    end else if (state_q == StCalc) begin
      rem_d = rem_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
      dvd_d = {dvd_q[XLEN-2:0], rem_ge};
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == LastCnt) begin
        state_d = StSign;
      end
    end else begin
      if (done) begin
        result_d = fin_result;
        state_d  = StIdle;
      end
      // Completion cycles also accept, so back-to-back ops need no bubble.
      if (accept) begin
        op_rem_d   = bus.div_op_i[1];
        neg_quot_d = a_neg ^ b_neg;
        neg_rem_d  = a_neg;
        rem_d      = '0;
        cnt_d      = '0;
        dvs_d      = abs_b;
        if (bus.div_divisor_i == '0) begin
          state_d = StFix;
          dvd_d   = bus.div_op_i[1] ? bus.div_dividend_i : AllOnes;
        end else if (is_signed && bus.div_dividend_i == MinInt &&
                     bus.div_divisor_i == AllOnes) begin
          state_d = StFix;
          dvd_d   = bus.div_op_i[1] ? '0 : MinInt;
        end else begin
          state_d = StCalc;
          dvd_d   = abs_a;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      op_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      op_rem_q   <= op_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign bus.div_busy_o   = busy;
  assign bus.div_valid_o  = valid;
  // The fresh result shows in the valid cycle itself; otherwise the last one is held.
  assign bus.div_result_o = valid ? fin_result : result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed self-checking bench for mdu_divider.
module tb_mdu_divider;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mdu_divider_if #(.XLEN(32)) bus ();

  mdu_divider #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start at the current negedge; returns at the negedge one cycle after T0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.div_start_i    = 1'b1;
    bus.div_op_i       = op;
    bus.div_dividend_i = a;
    bus.div_divisor_i  = b;
    @(posedge clk);
    @(negedge clk);
    bus.div_start_i = 1'b0;
  endtask

  // Cycle index 1 is the cycle after the start edge; returns at the negedge of the valid cycle.
  task automatic wait_valid(input string tag, input logic [31:0] exp_res, input int exp_lat,
                            input int exp_busy);
    int n;
    int nb;
    n  = 1;
    nb = 0;
    while (!bus.div_valid_o && n < 60) begin
      if (bus.div_busy_o) nb++;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_res"}, bus.div_result_o, exp_res);
    check_eq({tag, "_busy_at_valid"}, {31'b0, bus.div_busy_o}, 32'd0);
    check_eq({tag, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic post_check(input string tag, input logic [31:0] exp_res);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, {31'b0, bus.div_valid_o}, 32'd0);
    check_eq({tag, "_held"}, bus.div_result_o, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    issue(op, a, b);
    wait_valid(tag, exp_res, exp_lat, (exp_lat == 1) ? 0 : 32);
    post_check(tag, exp_res);
  endtask

  initial begin
    int nvalid;
    int nbusy;
    checks = 0;
    errors = 0;
    rst                = 1'b1;
    bus.div_start_i    = 1'b0;
    bus.div_op_i       = 2'b00;
    bus.div_dividend_i = '0;
    bus.div_divisor_i  = '0;
    bus.div_flush_i    = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'b0, bus.div_busy_o}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.div_valid_o}, 32'd0);
    check_eq("rst_result", bus.div_result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: the second start is driven in the first op's valid cycle.
    issue(OpDivu, 32'd100, 32'd7);
    wait_valid("divu_100_7", 32'd14, 33, 32);
    issue(OpRemu, 32'd100, 32'd7);
    wait_valid("remu_100_7", 32'd2, 33, 32);
    post_check("remu_100_7", 32'd2);

    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_ovf_ops", OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    run_op("div_by0", OpDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", OpRemu, 32'd5, 32'd0, 32'd5, 1);

    // Flush at cycle 10 with a stray start at cycle 5; last result (5) must survive.
    issue(OpDivu, 32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    bus.div_start_i    = 1'b1;
    bus.div_op_i       = OpDivu;
    bus.div_dividend_i = 32'd77;
    bus.div_divisor_i  = 32'd7;
    @(negedge clk);
    bus.div_start_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.div_flush_i = 1'b1;
    check_eq("flush_cyc_valid", {31'b0, bus.div_valid_o}, 32'd0);
    @(negedge clk);
    bus.div_flush_i = 1'b0;
    check_eq("flush_busy_after", {31'b0, bus.div_busy_o}, 32'd0);
    check_eq("flush_result_kept", bus.div_result_o, 32'd5);
    nvalid = 0;
    nbusy  = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.div_valid_o) nvalid++;
      if (bus.div_busy_o) nbusy++;
      @(negedge clk);
    end
    check_eq("flush_no_valid", nvalid, 0);
    check_eq("flush_stays_idle", nbusy, 0);
    check_eq("flush_result_still", bus.div_result_o, 32'd5);
    run_op("post_flush_divu", OpDivu, 32'h1234_5678, 32'h0000_0100, 32'h0012_3456, 33);

    // Async reset in the middle of an iteration.
    issue(OpDivu, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", {31'b0, bus.div_busy_o}, 32'd0);
    check_eq("midrst_valid", {31'b0, bus.div_valid_o}, 32'd0);
    check_eq("midrst_result", bus.div_result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu_max_1", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
